// File: rtl/cart_save_reader_pkg.sv
// Shared types and constants for the cartridge save-RAM upload path.
// Imported by the upload responder, its bus interface and the dirty tracker.
package cart_pkg;

   // Host byte-address width of the MiSTer ioctl bus.
   localparam int IOCTL_ADDR_WIDTH = 25;

   // Default save RAM geometry (8 KB battery SRAM).
   localparam int CART_ADDR_WIDTH = 13;
   localparam int CART_SAVE_SIZE  = 8192;

   // Returned for reads at or beyond the end of valid save data.
   localparam logic [7:0] CART_FILL_BYTE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_LAT  = 2'd2,
      ST_FILL = 2'd3
   } cart_state_e;

endpackage : cart_pkg

// File: rtl/cart_save_reader_if.sv
// Bundle of the ioctl upload, save-RAM and CPU-write signals around cart_save_reader.
// slave = responder view, master = framework/memory/CPU view.
interface cart_save_if #(
   parameter int ADDR_WIDTH = cart_pkg::CART_ADDR_WIDTH
);
   logic                                   ioctl_upload;
   logic                                   ioctl_rd;
   logic [cart_pkg::IOCTL_ADDR_WIDTH-1:0]  ioctl_addr;
   logic [7:0]                             ioctl_din;
   logic                                   ioctl_wait;
   logic [ADDR_WIDTH-1:0]                  mem_addr;
   logic                                   mem_rd;
   logic [7:0]                             mem_q;
   logic                                   mem_busy;
   logic                                   cpu_sram_we;
   logic                                   save_dirty;
   logic [7:0]                             checksum;

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, mem_q, mem_busy, cpu_sram_we,
      output ioctl_din, ioctl_wait, mem_addr, mem_rd, save_dirty, checksum
   );

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, mem_q, mem_busy, cpu_sram_we,
      input  ioctl_din, ioctl_wait, mem_addr, mem_rd, save_dirty, checksum
   );
endinterface : cart_save_if

// File: rtl/cart_save_reader_dirty_track.sv
// Save-RAM dirty flag: set by CPU writes, cleared when an upload session that
// delivered at least one byte ends. Reusable by any mapper with battery SRAM.
module cart_dirty_track (
   input  logic clk,
   input  logic reset_n,
   input  logic i_upload,
   input  logic i_byte_done,
   input  logic i_cpu_we,
   output logic o_save_dirty
);

   logic r_upload_q;
   logic r_session_byte;
   logic r_save_dirty;
   logic w_upload_fall;

   assign w_upload_fall = r_upload_q & ~i_upload;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_upload_q     <= 1'b0;
         r_session_byte <= 1'b0;
         r_save_dirty   <= 1'b0;
      end else begin
         r_upload_q <= i_upload;

         if (w_upload_fall)
            r_session_byte <= 1'b0;
         else if (i_byte_done)
            r_session_byte <= 1'b1;

         // A CPU write racing the end of an upload must not be lost.
         if (i_cpu_we)
            r_save_dirty <= 1'b1;
         else if (w_upload_fall && r_session_byte)
            r_save_dirty <= 1'b0;
      end
   end

   assign o_save_dirty = r_save_dirty;

endmodule : cart_dirty_track

// File: rtl/cart_save_reader.sv
// Host upload responder for cartridge save SRAM: serves ioctl_rd from save RAM, CPU has priority.
// Optional byte checksum of delivered data is enabled by defining CART_SAVE_CHECKSUM_EN.
module cart_save_reader
   import cart_pkg::*;
#(
   parameter int ADDR_WIDTH = CART_ADDR_WIDTH,
   parameter int SAVE_SIZE  = CART_SAVE_SIZE,
   parameter int RD_LAT     = 1
) (
   input logic        clk,
   input logic        reset_n,
   cart_save_if.slave bus
);

   localparam logic [IOCTL_ADDR_WIDTH-1:0] SAVE_LIMIT = IOCTL_ADDR_WIDTH'(SAVE_SIZE);
   localparam logic [1:0]                  LAT_LOAD   = 2'(RD_LAT);

   cart_state_e           r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_in_range;
   logic [1:0]            r_lat_cnt;
   logic [7:0]            r_din;
   logic                  r_wait;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_mem_rd;

   logic                  w_byte_done;
   logic                  w_save_dirty;

   // A byte is delivered on the edge that leaves LAT or FILL with the session still open.
   assign w_byte_done = bus.ioctl_upload &&
                        ((r_state == ST_LAT && r_lat_cnt == 2'd0) || r_state == ST_FILL);

   // The range check is taken on the full host address; truncation happens only afterwards,
   // so high addresses never alias back into the RAM. ARB's first cycle resolves the
   // latched range result, which is why fill bytes take two cycles like the decide step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_in_range <= 1'b0;
         r_lat_cnt  <= 2'd0;
         r_din      <= 8'h00;
         r_wait     <= 1'b0;
         r_mem_addr <= '0;
         r_mem_rd   <= 1'b0;
      end else begin
         // NOTE: default-low here makes mem_rd a single-cycle strobe without a separate clear path.
         r_mem_rd <= 1'b0;

         unique case (r_state)
            ST_IDLE: begin
               if (bus.ioctl_rd && bus.ioctl_upload) begin
                  r_addr     <= bus.ioctl_addr[ADDR_WIDTH-1:0];
                  r_in_range <= (bus.ioctl_addr < SAVE_LIMIT);
                  r_wait     <= 1'b1;
                  r_state    <= ST_ARB;
               end
            end

            ST_ARB: begin
               if (!bus.ioctl_upload) begin
                  r_wait  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (!r_in_range) begin
                  r_state <= ST_FILL;
               end else if (!bus.mem_busy) begin
                  r_mem_addr <= r_addr;
                  r_mem_rd   <= 1'b1;
                  r_lat_cnt  <= LAT_LOAD;
                  r_state    <= ST_LAT;
               end
            end

            ST_LAT: begin
               if (!bus.ioctl_upload) begin
                  r_wait  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_lat_cnt == 2'd0) begin
                  r_din   <= bus.mem_q;
                  r_wait  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 2'd1;
               end
            end

            ST_FILL: begin
               if (bus.ioctl_upload)
                  r_din <= CART_FILL_BYTE;
               r_wait  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   cart_dirty_track u_dirty (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_upload    (bus.ioctl_upload),
      .i_byte_done (w_byte_done),
      .i_cpu_we    (bus.cpu_sram_we),
      .o_save_dirty(w_save_dirty)
   );

`ifdef CART_SAVE_CHECKSUM_EN
   logic       r_ck_upload_q;
   logic [7:0] r_checksum;
   logic [7:0] w_byte_val;

   assign w_byte_val = (r_state == ST_FILL) ? CART_FILL_BYTE : bus.mem_q;

   // Sum restarts when a new session opens so the host can compare per upload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ck_upload_q <= 1'b0;
         r_checksum    <= 8'h00;
      end else begin
         r_ck_upload_q <= bus.ioctl_upload;
         if (bus.ioctl_upload && !r_ck_upload_q)
            r_checksum <= 8'h00;
         else if (w_byte_done)
            r_checksum <= r_checksum + w_byte_val;
      end
   end

   assign bus.checksum = r_checksum;
`else
   assign bus.checksum = 8'h00;
`endif

   assign bus.ioctl_din  = r_din;
   assign bus.ioctl_wait = r_wait;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_rd     = r_mem_rd;
   assign bus.save_dirty = w_save_dirty;

endmodule : cart_save_reader

// File: doc/cart_save_reader.md
Name: cart_save_reader

Overview:
Host-side upload responder for cartridge backup SRAM: the read-back counterpart of the ioctl download path that fills cart memory.
- Serves MiSTer ioctl upload reads (ioctl_rd / ioctl_din / ioctl_wait) from the cart save RAM.
- Arbitrates with CPU access; CPU always has priority.
- Tracks CPU writes, so the framework knows when a save upload is needed.

Parameters:
ADDR_WIDTH, 13, save RAM address width in bits (8 KB)
SAVE_SIZE, 8192, valid save bytes; addresses at or above return fill
RD_LAT, 1, memory read latency in cycles from mem_rd to valid mem_q (1..3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ioctl_upload  in  1  upload session active (level)
ioctl_rd  in  1  one-cycle byte read request
ioctl_addr  in  25  byte address for ioctl_rd
ioctl_din  out  8  byte returned to host
ioctl_wait  out  1  host must hold off while high
mem_addr  out  ADDR_WIDTH  save RAM address
mem_rd  out  1  one-cycle read strobe to save RAM
mem_q  in  8  save RAM read data
mem_busy  in  1  CPU owns save RAM this cycle
cpu_sram_we  in  1  CPU wrote save RAM this cycle
save_dirty  out  1  save RAM changed since last completed upload
checksum  out  8  running byte sum (see Optional Feature)

Behaviour:
- Reset is asynchronous on reset_n low. All of the following clear to 0:
  - ioctl_din, ioctl_wait, mem_addr, mem_rd, save_dirty, checksum.
  - Internal counters.
  - FSM returns to IDLE.
- FSM states: IDLE, ARB, LAT, FILL.
- IDLE:
  - On ioctl_rd & ioctl_upload, latch ioctl_addr and set ioctl_wait the next cycle.
  - If the latched address is below SAVE_SIZE, go to ARB; otherwise go to FILL.
  - ioctl_rd without ioctl_upload is ignored.
- ARB:
  - While mem_busy, hold with mem_rd=0.
  - Otherwise drive mem_addr = latched_addr[ADDR_WIDTH-1:0] and pulse mem_rd for exactly one cycle.
  - Load the latency counter with RD_LAT and go to LAT.
- LAT:
  - Decrement the counter each cycle.
  - When it reaches 0, register mem_q into ioctl_din, clear ioctl_wait on the same edge, and go to IDLE.
- FILL: one cycle; ioctl_din=8'hFF, ioctl_wait cleared, go to IDLE.
- Minimum latency from ioctl_rd to ioctl_wait low:
  - In-range, no contention: 2+RD_LAT cycles.
  - Out-of-range: 2 cycles.
- ioctl_din holds its value until the next accepted read completes.
- ioctl_rd arriving while not in IDLE is ignored; no queueing.
- ioctl_upload dropping in ARB/LAT/FILL aborts to IDLE and clears ioctl_wait next cycle. ioctl_din is not updated.
- Address compare uses the full 25-bit ioctl_addr. No wrap: ADDR_WIDTH truncation happens only after the range check.
- Dirty tracking:
  - cpu_sram_we sets save_dirty.
  - The falling edge of ioctl_upload clears save_dirty, but only if at least one byte completed during that session.
  - Set and clear in the same cycle: set wins.
  - Reset leaves save_dirty at 0.

Optional Feature:
CART_SAVE_CHECKSUM_EN
- Defined:
  - checksum accumulates (mod 256) every byte delivered on ioctl_din, including 8'hFF fill bytes.
  - checksum clears on the rising edge of ioctl_upload.
  - The host compares it against its own sum.
- Undefined: checksum is tied to 8'h00 and the accumulator logic is absent. The port remains so the instantiation is unchanged.

Decomposition:
- Shared package cart_pkg holds:
  - FSM state typedef (IDLE/ARB/LAT/FILL).
  - CART_FILL_BYTE = 8'hFF.
  - Default SAVE_SIZE / ADDR_WIDTH constants.
- One natural sub-module: cart_dirty_track. It contains the save_dirty flag, the upload edge detect and the "byte completed in session" flag, and is reusable by other mappers with SRAM.

Test Plan:
- Reset mid-LAT (RD_LAT=3, reset_n low at cycle 2) -> all outputs 0 asynchronously; FSM back in IDLE; next read works normally.
- Upload, ioctl_rd at addr 0x0010, mem holds 0x5A, RD_LAT=1, mem_busy=0 -> one mem_rd pulse at mem_addr 0x0010; ioctl_wait high exactly 3 cycles; ioctl_din=0x5A.
- Same read with mem_busy high for 4 cycles -> mem_rd withheld for those 4 cycles, then a single pulse; ioctl_wait high 7 cycles; data correct.
- ioctl_rd at addr 0x2000 (= SAVE_SIZE) and at 0x1_2000 -> no mem_rd; ioctl_din=0xFF; ioctl_wait high 2 cycles.
- cpu_sram_we pulse -> save_dirty=1; upload reading 3 bytes then ioctl_upload falls -> save_dirty=0.
  - Repeat with cpu_sram_we coincident with the falling edge -> save_dirty stays 1.
  - Upload with zero completed reads -> save_dirty stays 1.
- With CART_SAVE_CHECKSUM_EN, read bytes 0x80, 0x90, 0xFF(fill) -> checksum=0x0F; a new session clears it to 0. Without the macro, checksum stays 0x00 throughout.
